// File: rtl/dm_mmio_bridge.sv
// dm_mmio_bridge: routes CPU data-memory accesses to the data SRAM or to a
// small MMIO block (console TX FIFO, 64-bit machine timer, halt register).
// Read data returns one cycle after the request, matching the sync SRAM.
module dm_mmio_bridge #(
  parameter int unsigned TX_DEPTH = 4,
  parameter int unsigned TICK_DIV = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        DM_c_en,
  input  logic        DM_r_en,
  input  logic [31:0] DM_w_en,
  input  logic [31:0] DM_addr,
  input  logic [31:0] DM_w_data,
  output logic [31:0] DM_rd_data,
  output logic        sram_c_en,
  output logic        sram_r_en,
  output logic [31:0] sram_w_en,
  output logic [13:0] sram_addr,
  output logic [31:0] sram_w_data,
  input  logic [31:0] sram_r_data,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  output logic        timer_irq,
  output logic        halt,
  output logic [31:0] exit_code
);

  localparam int PW  = $clog2(TX_DEPTH);
  localparam int PSW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  localparam logic [7:0] OFF_TXDATA = 8'h00;
  localparam logic [7:0] OFF_TXSTAT = 8'h04;
  localparam logic [7:0] OFF_MT_LO  = 8'h08;
  localparam logic [7:0] OFF_MT_HI  = 8'h0C;
  localparam logic [7:0] OFF_CMP_LO = 8'h10;
  localparam logic [7:0] OFF_CMP_HI = 8'h14;
  localparam logic [7:0] OFF_HALT   = 8'h18;

  typedef enum logic [1:0] {RSEL_NONE, RSEL_SRAM, RSEL_MMIO} rsel_e;

  // ---------------- decode ----------------
  logic       sram_hit, mmio_hit, rd_req, mmio_wr;
  logic [7:0] offset;
  logic       wr_txdata, wr_txstat, wr_mt_lo, wr_mt_hi, wr_cmp_lo, wr_cmp_hi, wr_halt;

  assign sram_hit  = (DM_addr[31:16] == 16'h0000);
  assign mmio_hit  = (DM_addr[31:8] == 24'h100000);
  assign rd_req    = DM_c_en & DM_r_en;
  assign mmio_wr   = DM_c_en & ~DM_r_en & mmio_hit;
  assign offset    = DM_addr[7:0];

  // Only TXDATA honours the byte mask; other registers take the whole word.
  assign wr_txdata = mmio_wr & (offset == OFF_TXDATA) & (DM_w_en[7:0] == 8'hFF);
  assign wr_txstat = mmio_wr & (offset == OFF_TXSTAT);
  assign wr_mt_lo  = mmio_wr & (offset == OFF_MT_LO);
  assign wr_mt_hi  = mmio_wr & (offset == OFF_MT_HI);
  assign wr_cmp_lo = mmio_wr & (offset == OFF_CMP_LO);
  assign wr_cmp_hi = mmio_wr & (offset == OFF_CMP_HI);
  assign wr_halt   = mmio_wr & (offset == OFF_HALT);

  // ---------------- SRAM pass-through ----------------
  assign sram_c_en   = DM_c_en & sram_hit;
  assign sram_r_en   = DM_r_en;
  assign sram_w_en   = DM_r_en ? 32'h0 : DM_w_en;
  assign sram_addr   = DM_addr[15:2];
  assign sram_w_data = DM_w_data;

  // ---------------- console TX FIFO ----------------
  logic [7:0]  fifo_mem [TX_DEPTH];
  logic [PW:0] wptr_q, wptr_d, rptr_q, rptr_d, count;
  logic        ovf_q, ovf_d, full, empty, push_ok, pop;

  assign count    = wptr_q - rptr_q;
  assign full     = (count == (PW+1)'(TX_DEPTH));
  assign empty    = (count == '0);
  // Full is judged on the start-of-cycle state, so a same-cycle pop never frees room.
  assign push_ok  = wr_txdata & ~full;
  assign pop      = ~empty & tx_ready;
  assign tx_valid = ~empty;
  assign tx_data  = fifo_mem[rptr_q[PW-1:0]];

  // FIFO pointer and overflow next-state
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    ovf_d  = ovf_q;
    if (push_ok) wptr_d = wptr_q + 1'b1;
    if (pop)     rptr_d = rptr_q + 1'b1;
    if (wr_txdata & full)             ovf_d = 1'b1;
    else if (wr_txstat & DM_w_data[5]) ovf_d = 1'b0;
  end

  // FIFO pointer and overflow registers
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      ovf_q  <= ovf_d;
    end
  end

  // FIFO storage write
  always_ff @(posedge clk) begin
    // NOTE: storage is not reset; emptiness comes from the pointers, so stale bytes are never visible.
    if (push_ok) fifo_mem[wptr_q[PW-1:0]] <= DM_w_data[7:0];
  end

  // ---------------- machine timer ----------------
  logic [PSW-1:0] presc_q, presc_d;
  logic [31:0]    mt_lo_q, mt_lo_d, mt_hi_q, mt_hi_d;
  logic [31:0]    cmp_lo_q, cmp_lo_d, cmp_hi_q, cmp_hi_d;
  logic [32:0]    lo_sum;
  logic           tick, irq_q;

  assign tick      = (presc_q == PSW'(TICK_DIV - 1));
  assign lo_sum    = {1'b0, mt_lo_q} + 33'(tick);
  assign timer_irq = irq_q;

  // Timer next-state: a CPU write wins for its own half; the carry still reaches hi
  always_comb begin
    presc_d  = tick ? '0 : presc_q + 1'b1;
    mt_lo_d  = wr_mt_lo  ? DM_w_data : lo_sum[31:0];
    mt_hi_d  = wr_mt_hi  ? DM_w_data : mt_hi_q + 32'(lo_sum[32]);
    cmp_lo_d = wr_cmp_lo ? DM_w_data : cmp_lo_q;
    cmp_hi_d = wr_cmp_hi ? DM_w_data : cmp_hi_q;
  end

  // Timer registers; irq is compared on the current mtime, so it lags by one cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q  <= '0;
      mt_lo_q  <= '0;
      mt_hi_q  <= '0;
      cmp_lo_q <= '1;
      cmp_hi_q <= '1;
      irq_q    <= 1'b0;
    end else begin
      presc_q  <= presc_d;
      mt_lo_q  <= mt_lo_d;
      mt_hi_q  <= mt_hi_d;
      cmp_lo_q <= cmp_lo_d;
      cmp_hi_q <= cmp_hi_d;
      irq_q    <= ({mt_hi_q, mt_lo_q} >= {cmp_hi_q, cmp_lo_q});
    end
  end

  // ---------------- halt ----------------
  logic        halt_q;
  logic [31:0] exit_code_q;

  assign halt      = halt_q;
  assign exit_code = exit_code_q;

  // Sticky halt request and exit code
  always_ff @(posedge clk) begin
    if (rst) begin
      halt_q      <= 1'b0;
      exit_code_q <= '0;
    end else if (wr_halt) begin
      halt_q      <= 1'b1;
      exit_code_q <= DM_w_data;
    end
  end

  // ---------------- read return ----------------
  rsel_e       rsel_q, rsel_d;
  logic        rd_vld_q;
  logic [31:0] mmio_rdata_d, mmio_rdata_q, last_q, rd_ret;

  // MMIO read mux and target select for the issuing cycle
  always_comb begin
    mmio_rdata_d = '0;
    unique case (offset)
      OFF_TXSTAT: mmio_rdata_d = {26'b0, ovf_q, full, 4'(count)};
      OFF_MT_LO:  mmio_rdata_d = mt_lo_q;
      OFF_MT_HI:  mmio_rdata_d = mt_hi_q;
      OFF_CMP_LO: mmio_rdata_d = cmp_lo_q;
      OFF_CMP_HI: mmio_rdata_d = cmp_hi_q;
      OFF_HALT:   mmio_rdata_d = exit_code_q;
      default:    mmio_rdata_d = '0;
    endcase
    if (sram_hit)      rsel_d = RSEL_SRAM;
    else if (mmio_hit) rsel_d = RSEL_MMIO;
    else               rsel_d = RSEL_NONE;
  end

  // Returned word for a read issued last cycle
  always_comb begin
    unique case (rsel_q)
      RSEL_SRAM: rd_ret = sram_r_data;
      RSEL_MMIO: rd_ret = mmio_rdata_q;
      default:   rd_ret = '0;
    endcase
  end

  assign DM_rd_data = rd_vld_q ? rd_ret : last_q;

  // Capture read select/data; remember the last returned word for idle cycles
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_vld_q     <= 1'b0;
      rsel_q       <= RSEL_NONE;
      mmio_rdata_q <= '0;
      last_q       <= '0;
    end else begin
      rd_vld_q <= rd_req;
      if (rd_req) begin
        rsel_q       <= rsel_d;
        mmio_rdata_q <= mmio_rdata_d;
      end
      if (rd_vld_q) last_q <= rd_ret;
    end
  end

endmodule

// File: tb/tb_dm_mmio_bridge.sv
// Directed self-checking bench for dm_mmio_bridge (TX_DEPTH=4, TICK_DIV=1).
module tb_dm_mmio_bridge;

  localparam logic [31:0] A_TXDATA = 32'h1000_0000;
  localparam logic [31:0] A_TXSTAT = 32'h1000_0004;
  localparam logic [31:0] A_MT_LO  = 32'h1000_0008;
  localparam logic [31:0] A_MT_HI  = 32'h1000_000C;
  localparam logic [31:0] A_CMP_LO = 32'h1000_0010;
  localparam logic [31:0] A_CMP_HI = 32'h1000_0014;
  localparam logic [31:0] A_HALT   = 32'h1000_0018;

  logic        clk = 1'b0;
  logic        rst;
  logic        DM_c_en, DM_r_en;
  logic [31:0] DM_w_en, DM_addr, DM_w_data, DM_rd_data;
  logic        sram_c_en, sram_r_en;
  logic [31:0] sram_w_en, sram_w_data, sram_r_data;
  logic [13:0] sram_addr;
  logic        tx_valid, tx_ready, timer_irq, halt;
  logic [7:0]  tx_data;
  logic [31:0] exit_code;

  int checks = 0;
  int errors = 0;

  dm_mmio_bridge #(.TX_DEPTH(4), .TICK_DIV(1)) dut (
    .clk(clk), .rst(rst),
    .DM_c_en(DM_c_en), .DM_r_en(DM_r_en), .DM_w_en(DM_w_en), .DM_addr(DM_addr),
    .DM_w_data(DM_w_data), .DM_rd_data(DM_rd_data),
    .sram_c_en(sram_c_en), .sram_r_en(sram_r_en), .sram_w_en(sram_w_en),
    .sram_addr(sram_addr), .sram_w_data(sram_w_data), .sram_r_data(sram_r_data),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .timer_irq(timer_irq), .halt(halt), .exit_code(exit_code)
  );

  always #5 clk = ~clk;

  // Synchronous SRAM model; idle cycles drive a junk word so hold behaviour is visible
  logic [31:0] sram_mem [16384];
  always @(posedge clk) begin
    if (sram_c_en && !sram_r_en)
      sram_mem[sram_addr] <= (sram_mem[sram_addr] & ~sram_w_en) | (sram_w_data & sram_w_en);
    if (sram_c_en && sram_r_en) sram_r_data <= sram_mem[sram_addr];
    else                        sram_r_data <= 32'hBAD0_BAD0;
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_idle();
    DM_c_en = 1'b0; DM_r_en = 1'b1; DM_w_en = '0; DM_addr = '0; DM_w_data = '0;
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [31:0] m);
    DM_c_en = 1'b1; DM_r_en = 1'b0; DM_addr = a; DM_w_data = d; DM_w_en = m;
    cyc();
    bus_idle();
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    DM_c_en = 1'b1; DM_r_en = 1'b1; DM_addr = a; DM_w_en = '0;
    cyc();
    bus_idle();
    d = DM_rd_data;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    rst = 1'b1; tx_ready = 1'b0; bus_idle();
    repeat (3) cyc();
    checks++; if (DM_rd_data !== 32'h0) begin errors++; $display("FAIL rst_rd_data got %h exp %h", DM_rd_data, 32'h0); end
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL rst_tx_valid got %b exp 0", tx_valid); end
    checks++; if (timer_irq !== 1'b0) begin errors++; $display("FAIL rst_irq got %b exp 0", timer_irq); end
    checks++; if ({halt, exit_code} !== 33'h0) begin errors++; $display("FAIL rst_halt got %b/%h exp 0/0", halt, exit_code); end
    rst = 1'b0;
    bus_read(A_CMP_HI, d);
    checks++; if (d !== 32'hFFFF_FFFF) begin errors++; $display("FAIL rst_cmp_hi got %h exp %h", d, 32'hFFFF_FFFF); end
    bus_read(A_TXSTAT, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL rst_txstat got %h exp %h", d, 32'h0); end
  endtask

  task automatic test_sram();
    logic [31:0] d;
    DM_c_en = 1'b1; DM_r_en = 1'b0; DM_addr = 32'h40; DM_w_data = 32'hDEAD_BEEF; DM_w_en = '1;
    #1;
    checks++; if ({sram_c_en, sram_addr, sram_w_en} !== {1'b1, 14'h10, 32'hFFFF_FFFF}) begin errors++; $display("FAIL sram_wr_ctl got %b %h %h exp 1 0010 ffffffff", sram_c_en, sram_addr, sram_w_en); end
    cyc(); bus_idle();
    DM_c_en = 1'b1; DM_r_en = 1'b1; DM_addr = 32'h40; DM_w_en = '1;
    #1;
    checks++; if ({sram_c_en, sram_r_en, sram_addr, sram_w_en} !== {2'b11, 14'h10, 32'h0}) begin errors++; $display("FAIL sram_rd_ctl got %b %b %h %h exp 1 1 0010 00000000", sram_c_en, sram_r_en, sram_addr, sram_w_en); end
    checks++; if (DM_rd_data !== 32'h0) begin errors++; $display("FAIL sram_rd_early got %h exp %h", DM_rd_data, 32'h0); end
    cyc(); bus_idle();
    checks++; if (DM_rd_data !== 32'hDEAD_BEEF) begin errors++; $display("FAIL sram_rd got %h exp %h", DM_rd_data, 32'hDEAD_BEEF); end
    repeat (2) cyc();
    checks++; if (DM_rd_data !== 32'hDEAD_BEEF) begin errors++; $display("FAIL rd_hold got %h exp %h", DM_rd_data, 32'hDEAD_BEEF); end
    bus_write(32'h40, 32'h1234_5678, 32'h0000_FFFF);
    bus_read(32'h40, d);
    checks++; if (d !== 32'hDEAD_5678) begin errors++; $display("FAIL sram_mask got %h exp %h", d, 32'hDEAD_5678); end
  endtask

  task automatic test_unmapped();
    logic [31:0] d;
    DM_c_en = 1'b1; DM_r_en = 1'b1; DM_addr = 32'h2000_0000;
    #1;
    checks++; if (sram_c_en !== 1'b0) begin errors++; $display("FAIL unmap_sram_en got %b exp 0", sram_c_en); end
    cyc(); bus_idle();
    checks++; if (DM_rd_data !== 32'h0) begin errors++; $display("FAIL unmap_rd got %h exp %h", DM_rd_data, 32'h0); end
    bus_write(32'h0001_0040, 32'h1111_1111, '1);
    bus_read(32'h40, d);
    checks++; if (d !== 32'hDEAD_5678) begin errors++; $display("FAIL unmap_wr_dropped got %h exp %h", d, 32'hDEAD_5678); end
    bus_read(32'h1000_0020, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL mmio_hole_rd got %h exp %h", d, 32'h0); end
  endtask

  task automatic test_tx_overflow();
    logic [31:0] d;
    bus_write(A_TXDATA, 32'h99, 32'h0000_00F0);
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL tx_partial_mask got %b exp 0", tx_valid); end
    for (int i = 0; i < 5; i++) bus_write(A_TXDATA, 32'h41 + i, '1);
    bus_read(A_TXSTAT, d);
    checks++; if (d !== 32'h34) begin errors++; $display("FAIL txstat_ovf got %h exp %h", d, 32'h34); end
    bus_read(A_TXDATA, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL txdata_rd got %h exp %h", d, 32'h0); end
    tx_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++; if ({tx_valid, tx_data} !== {1'b1, 8'(8'h41 + i)}) begin errors++; $display("FAIL tx_drain[%0d] got %b/%h exp 1/%h", i, tx_valid, tx_data, 8'(8'h41 + i)); end
      cyc();
    end
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL tx_empty got %b exp 0", tx_valid); end
    tx_ready = 1'b0;
    bus_write(A_TXSTAT, 32'h20, '1);
    bus_read(A_TXSTAT, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL ovf_clear got %h exp %h", d, 32'h0); end
  endtask

  task automatic test_tx_full_pop_push();
    logic [31:0] d;
    for (int i = 0; i < 4; i++) bus_write(A_TXDATA, 32'h50 + i, '1);
    tx_ready = 1'b1;
    bus_write(A_TXDATA, 32'h54, '1);
    tx_ready = 1'b0;
    bus_read(A_TXSTAT, d);
    checks++; if (d !== 32'h23) begin errors++; $display("FAIL full_pop_push got %h exp %h", d, 32'h23); end
    tx_ready = 1'b1;
    for (int i = 1; i < 4; i++) begin
      checks++; if ({tx_valid, tx_data} !== {1'b1, 8'(8'h50 + i)}) begin errors++; $display("FAIL pp_drain[%0d] got %b/%h exp 1/%h", i, tx_valid, tx_data, 8'(8'h50 + i)); end
      cyc();
    end
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL pp_empty got %b exp 0", tx_valid); end
    tx_ready = 1'b0;
    bus_write(A_TXSTAT, 32'h20, '1);
  endtask

  task automatic test_timer();
    logic [31:0] d;
    bus_write(A_CMP_LO, 32'd10, '1);
    bus_write(A_CMP_HI, 32'd0, '1);
    bus_write(A_MT_HI, 32'd0, '1);
    bus_write(A_MT_LO, 32'hFFFF_FFFF, '1);
    bus_read(A_MT_HI, d);
    checks++; if (d !== 32'd0) begin errors++; $display("FAIL mt_hi_before got %h exp %h", d, 32'd0); end
    bus_read(A_MT_HI, d);
    checks++; if (d !== 32'd1) begin errors++; $display("FAIL mt_hi_carry got %h exp %h", d, 32'd1); end
    // lo write coincides with the wrapping tick: lo takes the write, hi still gets the carry
    bus_write(A_MT_LO, 32'hFFFF_FFFF, '1);
    bus_write(A_MT_LO, 32'd5, '1);
    bus_read(A_MT_LO, d);
    checks++; if (d !== 32'd5) begin errors++; $display("FAIL mt_lo_wr_prio got %h exp %h", d, 32'd5); end
    bus_read(A_MT_HI, d);
    checks++; if (d !== 32'd2) begin errors++; $display("FAIL mt_hi_carry_on_lo_wr got %h exp %h", d, 32'd2); end
    checks++; if (timer_irq !== 1'b1) begin errors++; $display("FAIL irq_high got %b exp 1", timer_irq); end
    bus_write(A_MT_HI, 32'd0, '1);
    bus_write(A_MT_LO, 32'd8, '1);
    bus_read(A_MT_LO, d);
    checks++; if (d !== 32'd8) begin errors++; $display("FAIL mt_lo_8 got %h exp %h", d, 32'd8); end
    checks++; if (timer_irq !== 1'b0) begin errors++; $display("FAIL irq_at_8 got %b exp 0", timer_irq); end
    cyc();
    checks++; if (timer_irq !== 1'b0) begin errors++; $display("FAIL irq_at_9 got %b exp 0", timer_irq); end
    cyc();
    checks++; if (timer_irq !== 1'b1) begin errors++; $display("FAIL irq_after_10 got %b exp 1", timer_irq); end
  endtask

  task automatic test_halt();
    logic [31:0] d;
    checks++; if (halt !== 1'b0) begin errors++; $display("FAIL halt_pre got %b exp 0", halt); end
    bus_write(A_HALT, 32'h0000_002A, '1);
    checks++; if ({halt, exit_code} !== {1'b1, 32'd42}) begin errors++; $display("FAIL halt_set got %b/%h exp 1/%h", halt, exit_code, 32'd42); end
    bus_read(A_HALT, d);
    checks++; if (d !== 32'd42) begin errors++; $display("FAIL halt_rd got %h exp %h", d, 32'd42); end
    bus_read(32'h40, d);
    repeat (5) cyc();
    checks++; if (halt !== 1'b1) begin errors++; $display("FAIL halt_sticky got %b exp 1", halt); end
  endtask

  task automatic test_reset_mid_op();
    logic [31:0] d;
    bus_write(A_TXDATA, 32'h77, '1);
    bus_write(A_CMP_LO, 32'h5, '1);
    DM_c_en = 1'b1; DM_r_en = 1'b1; DM_addr = A_HALT;
    cyc(); bus_idle();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    checks++; if (DM_rd_data !== 32'h0) begin errors++; $display("FAIL midrst_rd got %h exp %h", DM_rd_data, 32'h0); end
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL midrst_fifo got %b exp 0", tx_valid); end
    checks++; if ({halt, exit_code} !== 33'h0) begin errors++; $display("FAIL midrst_halt got %b/%h exp 0/0", halt, exit_code); end
    bus_read(A_CMP_LO, d);
    checks++; if (d !== 32'hFFFF_FFFF) begin errors++; $display("FAIL midrst_cmp_lo got %h exp %h", d, 32'hFFFF_FFFF); end
    bus_read(A_TXSTAT, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL midrst_txstat got %h exp %h", d, 32'h0); end
  endtask

  initial begin
    test_reset();
    test_sram();
    test_unmapped();
    test_tx_overflow();
    test_tx_full_pop_push();
    test_timer();
    test_halt();
    test_reset_mid_op();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dm_mmio_bridge.md
Name: dm_mmio_bridge

Overview:
- Sits directly downstream of the CPU data-memory port (DM_*).
- Decodes each access and routes it either to the data SRAM or to a small MMIO block: console TX FIFO, 64-bit machine timer, and a simulation halt register.
- Returns read data with the same 1-cycle latency the CPU already expects from the synchronous SRAM.

Parameters:
TX_DEPTH, 4, console TX FIFO entries (power of 2, ≥2)
TICK_DIV, 1, clk cycles per mtime increment (≥1)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
DM_c_en  in  1  access enable (1 = access this cycle)
DM_r_en  in  1  1 = read, 0 = write (valid when DM_c_en)
DM_w_en  in  32  per-bit write mask, 1 = write bit
DM_addr  in  32  byte address, word aligned
DM_w_data  in  32  write data
DM_rd_data  out  32  read data, valid cycle after read
sram_c_en  out  1  SRAM enable
sram_r_en  out  1  SRAM read
sram_w_en  out  32  SRAM bit write mask
sram_addr  out  14  SRAM word address (DM_addr[15:2])
sram_w_data  out  32  SRAM write data
sram_r_data  in  32  SRAM read data (1-cycle sync)
tx_valid  out  1  console byte available
tx_data  out  8  console byte (FIFO head)
tx_ready  in  1  console consumes head when tx_valid&tx_ready
timer_irq  out  1  mtime >= mtimecmp (registered)
halt  out  1  sticky halt request
exit_code  out  32  value written to HALT

Behaviour:
- Clock and reset: one clock (clk); synchronous, active-high reset (rst).
- Address decode:
  - SRAM: DM_addr[31:16] == 0.
  - MMIO: DM_addr[31:8] == 24'h100000.
  - Anything else is unmapped.
- SRAM path (combinational pass-through):
  - sram_c_en = DM_c_en & SRAM hit.
  - sram_r_en = DM_r_en.
  - sram_w_en = DM_r_en ? 0 : DM_w_en.
  - sram_addr and sram_w_data are passed through.
- MMIO registers (offset from 0x1000_0000):
  - 0x00 TXDATA W: push DM_w_data[7:0] when DM_w_en[7:0] == 8'hFF. Reads return 0.
  - 0x04 TXSTAT R: {26'b0, ovf, full, count[3:0]}. Writing 1 to bit 5 clears ovf.
  - 0x08 / 0x0C MTIME lo/hi, RW.
  - 0x10 / 0x14 MTIMECMP lo/hi, RW.
  - 0x18 HALT W: sets halt = 1 and exit_code = DM_w_data. Reads return exit_code.
  - MMIO writes use the full word; bit masks are ignored except at TXDATA.
- Read return:
  - Registered select rsel (SRAM / MMIO / NONE) captured on each cycle with DM_c_en & DM_r_en.
  - Next cycle: DM_rd_data = sram_r_data when rsel is SRAM; the registered MMIO read value when MMIO; 0 otherwise.
  - Holds the last returned value when no read was issued.
- Unmapped accesses: writes dropped, reads return 0. No error signalled.
- TX FIFO:
  - Circular buffer with log2(TX_DEPTH)+1-bit pointers; count = wptr - rptr.
  - Push while full: byte dropped, ovf set (sticky).
  - Full is evaluated at cycle start, so a push is rejected even if a pop happens the same cycle.
  - Pop and an accepted push in the same cycle: count unchanged.
  - tx_valid = !empty; tx_data = head.
- Timer:
  - Prescale counter 0..TICK_DIV-1; mtime += 1 (64-bit, wraps) on terminal count.
  - A CPU write to a MTIME half in the same cycle takes priority over the increment for that half. The other half still receives any carry.
  - timer_irq is registered from mtime >= mtimecmp, so it lags a timer update by 1 cycle.
- halt is sticky until rst. Accesses continue normally after halt.
- Reset values:
  - DM_rd_data = 0, rsel = NONE, FIFO empty, ovf = 0.
  - mtime = 0, prescaler = 0, mtimecmp = all-ones.
  - timer_irq = 0, halt = 0, exit_code = 0.
  - tx_valid = 0.
- Reset mid-operation:
  - FIFO contents discarded.
  - A pending read returns 0 on the cycle after reset deasserts.

Test Plan:
- SRAM write 0xDEADBEEF at 0x0000_0040 with mask 0xFFFF_FFFF, then read it back → sram_addr = 0x10 both times; DM_rd_data = 0xDEADBEEF exactly one cycle after the read.
- With tx_ready = 0, push 0x41, 0x42, 0x43, 0x44, 0x45 to TXDATA (TX_DEPTH = 4) → TXSTAT reads 0x34 (ovf=1, full=1, count=4). Raise tx_ready → bytes 41, 42, 43, 44 emitted in order, then tx_valid = 0.
- FIFO full plus a simultaneous pop and push → push rejected, count becomes 3, ovf set.
- TICK_DIV = 1: write MTIMECMP = 10, MTIME lo = 0xFFFF_FFFF, MTIME hi = 0 → hi becomes 1 after the next tick. Then write MTIME hi = 0, lo = 8 → timer_irq rises 1 cycle after mtime reaches 10.
- Write 0x0000_002A to HALT → halt = 1, exit_code = 42. HALT read returns 42. halt stays high until rst.
- Read 0x2000_0000 (unmapped) → DM_rd_data = 0, sram_c_en = 0. Assert rst during a pending MMIO read → DM_rd_data = 0, FIFO empty, mtimecmp = all-ones.
